task_9_nn_arbiter: RTL

//  Shares one network_xor_wrapper instance between NUM_REQ input streams.

---
 rtl/task_9_nn_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/task_9_nn_arbiter.sv
// task_9_nn_arbiter
//   Shares one network_xor_wrapper between NUM_REQ input streams. Requesters
//   are granted round-robin. The granted vector is held on o_nn_data with
//   o_nn_valid until the network accepts it. Each accepted vector leaves its
//   requester index in a tag FIFO. Each network result pops the head tag and
//   is returned to that requester one cycle later.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid         per-requester vector valid
//   i_req_data          requester k vector at [k*IN_WIDTH +: IN_WIDTH]
//   o_req_ready         one-hot, combinational: requester k consumed this cycle
//   o_nn_valid          vector valid towards network (in_data_vld)
//   o_nn_data           vector towards network; bit 2 feeds network in_data[0]
//   i_nn_ready          network in_data_rdy
//   i_nn_result         network result_data
//   i_nn_result_valid   network result_vld
//   o_rsp_valid         one-hot result pulse per requester
//   o_rsp_data          result bit per requester, qualified by o_rsp_valid
//   o_busy              vector held or results still outstanding
//   o_err               sticky: a result arrived with no outstanding tag

module task_9_nn_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned IN_WIDTH  = 3,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic                         o_nn_valid,
    output logic [IN_WIDTH-1:0]          o_nn_data,
    input  logic                         i_nn_ready,
    input  logic                         i_nn_result,
    input  logic                         i_nn_result_valid,
    output logic [NUM_REQ-1:0]           o_rsp_valid,
    output logic [NUM_REQ-1:0]           o_rsp_data,
    output logic                         o_busy,
    output logic                         o_err
);

    localparam int unsigned REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t             state;
    logic [REQ_W-1:0]   rr_ptr;
    logic [REQ_W-1:0]   cur_tag;

    // Round-robin search results
    logic               win_found;
    logic [REQ_W-1:0]   win_idx;
    logic [IN_WIDTH-1:0] win_data;
    logic [IN_WIDTH-1:0] req_slice [NUM_REQ];

    // Tag FIFO
    logic [REQ_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [REQ_W-1:0]   head_tag;
    logic               fifo_full;
    logic               fifo_empty;

    logic               grant;
    logic               push;
    logic               pop;

    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            req_slice[k] = i_req_data[k*IN_WIDTH +: IN_WIDTH];
        end
    end

    // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin : rr_search
        logic [REQ_W:0]   sum;
        logic [REQ_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        sum       = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (REQ_W+1)'(i);
            if (sum >= (REQ_W+1)'(NUM_REQ)) begin
                sum = sum - (REQ_W+1)'(NUM_REQ);
            end
            idx = sum[REQ_W-1:0];
            if (!win_found && i_req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
                win_data  = req_slice[idx];
            end
        end
    end

    assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count == '0);
    assign head_tag   = tag_mem[rd_ptr];

    // Full is judged on the count before any same-cycle pop, so a freed slot
    // only becomes grantable on the following cycle.
    assign grant = (state == S_IDLE) && win_found && !fifo_full && !i_rst;
    assign push  = (state == S_ISSUE) && i_nn_ready && !i_rst;
    assign pop   = i_nn_result_valid && !fifo_empty;

    always_comb begin
        o_req_ready = '0;
        if (grant) begin
            o_req_ready[win_idx] = 1'b1;
        end
    end

    assign o_busy = (state == S_ISSUE) || !fifo_empty;

    // Tag storage carries no reset; pointers and count define its contents.
    always_ff @(posedge i_clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= cur_tag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            cur_tag     <= '0;
            o_nn_valid  <= 1'b0;
            o_nn_data   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_err       <= 1'b0;
        end else begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;

            case (state)
                S_IDLE: begin
                    if (grant) begin
                        o_nn_data  <= win_data;
                        cur_tag    <= win_idx;
                        o_nn_valid <= 1'b1;
                        rr_ptr     <= (win_idx == REQ_W'(NUM_REQ - 1)) ? '0
                                                                       : win_idx + REQ_W'(1);
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Always return to IDLE after a transfer: no back-to-back issue.
                    if (i_nn_ready) begin
                        o_nn_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr                <= rd_ptr + PTR_W'(1);
                o_rsp_valid[head_tag] <= 1'b1;
                o_rsp_data[head_tag]  <= i_nn_result;
            end else if (i_nn_result_valid) begin
                o_err <= 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
